// File: rtl/ram_be_sp.sv
// Single-port-pair block RAM with byte-lane write enables, registered read, range error flag
// and a post-reset zero-fill sequence. Define RAM_BYPASS_EN for write-first same-address reads.
module ram_be_sp #(
  parameter int NUM_WORD   = 1024,
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [WORD_WIDTH-1:0]            wdata,
  input  logic [WORD_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic                             ren,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [WORD_WIDTH-1:0]            rdata,
  output logic                             rvalid,
  output logic                             err,
  output logic                             busy
);

  // state | meaning
  // CLEAR | zero-filling mem[clr_cnt]; requests ignored, busy=1
  // RUN   | normal read/write service

  localparam int NUM_LANES = WORD_WIDTH / BYTE_WIDTH;
  localparam int IDX_W     = (NUM_WORD > 1) ? $clog2(NUM_WORD) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_WORD);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_WORD - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        clr_cnt, clr_cnt_nxt;
  logic [WORD_WIDTH-1:0]   mem [NUM_WORD];

  logic                    wr_req, rd_req;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_ok;
  logic [IDX_W-1:0]        widx, ridx;
  logic [WORD_WIDTH-1:0]   rd_word;

  assign busy        = (state == CLEAR);
  assign wr_req      = wen & ~busy;
  assign rd_req      = ren & ~busy;
  assign wr_in_range = (waddr < ADDR_LIMIT);
  assign rd_in_range = (raddr < ADDR_LIMIT);
  assign wr_ok       = wr_req & wr_in_range;
  assign widx        = waddr[IDX_W-1:0];
  assign ridx        = raddr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + IDX_W'(1);
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = RUN;
          clr_cnt_nxt = '0;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Array has no reset; the CLEAR sweep is what guarantees defined contents.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wbe[i]) mem[widx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = mem[ridx];
`ifdef RAM_BYPASS_EN
    // Write-first: enabled lanes of a colliding write replace the stale array data.
    if (wr_ok && rd_in_range && (widx == ridx)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wbe[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_req;
      err    <= (rd_req & ~rd_in_range) | (wr_req & ~wr_in_range);
      if (rd_req) rdata <= rd_in_range ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_ram_be_sp.sv
// Directed bench for ram_be_sp: clear sequence, byte-lane writes, collision, range errors, reset restart.
// Expected collision data follows RAM_BYPASS_EN when the same macro is defined for the bench.
module tb_ram_be_sp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  ram_be_sp #(
    .NUM_WORD(1024), .WORD_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input logic exp_err);
    ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
    check({tag, ".rdata"}, rdata, exp);
    check({tag, ".rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
    tick();
    check({tag, ".hold"}, rdata, exp);
    check({tag, ".rvalid_off"}, {31'd0, rvalid}, 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic exp_err);
    wen = 1'b1; waddr = a; wdata = d; wbe = be;
    tick();
    wen = 1'b0;
    check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic wait_clear(input string tag, input logic drive_reqs);
    int edges = 0;
    int bad = 0;
    if (drive_reqs) begin
      wen = 1'b1; waddr = 32'd3; wdata = 32'hFFFF_FFFF; wbe = 4'hF;
      ren = 1'b1; raddr = 32'd3;
    end
    while (edges < 2000) begin
      tick();
      edges++;
      if (rvalid !== 1'b0 || err !== 1'b0) bad++;
      if (busy !== 1'b1) break;
    end
    wen = 1'b0; ren = 1'b0;
    check({tag, ".busy_edges"}, edges, 32'd1024);
    check({tag, ".quiet"}, bad, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_coll;
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; wdata = '0; wbe = '0; raddr = '0;
    tick(); tick();
    check("rst.busy", {31'd0, busy}, 32'd1);
    check("rst.rdata", rdata, 32'd0);
    check("rst.rvalid", {31'd0, rvalid}, 32'd0);
    check("rst.err", {31'd0, err}, 32'd0);

    rst_n = 1'b1;
    wait_clear("clear1", 1'b1);

    do_read("init0", 32'd0, 32'h0, 1'b0);
    do_read("init511", 32'd511, 32'h0, 1'b0);
    do_read("init1023", 32'd1023, 32'h0, 1'b0);
    do_read("busy_wr_dropped", 32'd3, 32'h0, 1'b0);

    do_write("w5a", 32'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    do_write("w5b", 32'd5, 32'h1122_3344, 4'b0101, 1'b0);
    do_read("r5", 32'd5, 32'hDE22_BE44, 1'b0);
    do_write("w5nop", 32'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    do_read("r5nop", 32'd5, 32'hDE22_BE44, 1'b0);

`ifdef RAM_BYPASS_EN
    exp_coll = 32'hCAFE_F00D;
`else
    exp_coll = 32'h0000_0000;
`endif
    wen = 1'b1; waddr = 32'd7; wdata = 32'hCAFE_F00D; wbe = 4'hF;
    ren = 1'b1; raddr = 32'd7;
    tick();
    wen = 1'b0; ren = 1'b0;
    check("coll.rdata", rdata, exp_coll);
    check("coll.rvalid", {31'd0, rvalid}, 32'd1);
    do_read("r7after", 32'd7, 32'hCAFE_F00D, 1'b0);

    // Back-to-back reads, no idle cycle between them.
    ren = 1'b1; raddr = 32'd5;
    tick();
    raddr = 32'd7;
    check("b2b.first", rdata, 32'hDE22_BE44);
    tick();
    ren = 1'b0;
    check("b2b.second", rdata, 32'hCAFE_F00D);
    check("b2b.rvalid", {31'd0, rvalid}, 32'd1);

    do_read("r1024", 32'd1024, 32'h0, 1'b1);
    do_write("w976", 32'd976, 32'h1234_5678, 4'hF, 1'b0);
    do_write("w2000", 32'd2000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    tick();
    check("w2000.err_off", {31'd0, err}, 32'd0);
    do_read("r976", 32'd976, 32'h1234_5678, 1'b0);

    do_write("w900", 32'd900, 32'hA5A5_A5A5, 4'hF, 1'b0);
    do_read("r900", 32'd900, 32'hA5A5_A5A5, 1'b0);

    // Reset in RUN with a read request pending: the read must not complete.
    ren = 1'b1; raddr = 32'd900;
    rst_n = 1'b0;
    tick();
    ren = 1'b0;
    check("rstrun.rvalid", {31'd0, rvalid}, 32'd0);
    check("rstrun.rdata", rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("midclear.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_clear("clear2", 1'b0);
    do_read("r900clr", 32'd900, 32'h0, 1'b0);
    do_read("r976clr", 32'd976, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
